// File: rtl/results_writer_pkg.sv
// Constants and state encoding shared by the results writer and the results sender.
package results_writer_pkg;

  localparam int unsigned NUMBER_OF_T_ADDRESS   = 32'd1;
  localparam int unsigned NUMBER_OF_X_ADDRESS   = 32'd2;
  localparam int unsigned STARTING_OF_T_ADDRESS = 32'd3;
  localparam int unsigned STARTING_OF_X_ADDRESS = 32'd10;
  localparam int unsigned MAX_T = STARTING_OF_X_ADDRESS - STARTING_OF_T_ADDRESS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_T = 3'd1,
    WAIT_X = 3'd2,
    WR_NT  = 3'd3,
    WR_NX  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/results_writer_write_address_gen.sv
// Step/index bookkeeping for the results RAM: T slot address and running X base address.
module write_address_gen
  import results_writer_pkg::*;
#(
  parameter int ADDRESS_WIDTH         = 13,
  parameter int COUNT_WIDTH           = 8,
  parameter int STARTING_OF_T_ADDRESS = results_writer_pkg::STARTING_OF_T_ADDRESS,
  parameter int STARTING_OF_X_ADDRESS = results_writer_pkg::STARTING_OF_X_ADDRESS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     t_accept,
  input  logic                     x_accept,
  input  logic [COUNT_WIDTH-1:0]   num_x,
  output logic [COUNT_WIDTH-1:0]   t_count,
  output logic [COUNT_WIDTH-1:0]   t_count_nxt,
  output logic                     last_x,
  output logic [ADDRESS_WIDTH-1:0] t_addr,
  output logic [ADDRESS_WIDTH-1:0] x_addr
);

  logic [COUNT_WIDTH-1:0]   t_count_q, t_count_d;
  logic [COUNT_WIDTH-1:0]   x_index_q, x_index_d;
  logic [ADDRESS_WIDTH-1:0] x_base_q, x_base_d;

  assign last_x = (x_index_q == (num_x - COUNT_WIDTH'(1)));

  always_comb begin
    t_count_d = t_count_q;
    x_index_d = x_index_q;
    x_base_d  = x_base_q;
    if (clear) begin
      t_count_d = '0;
      x_index_d = '0;
      x_base_d  = ADDRESS_WIDTH'(STARTING_OF_X_ADDRESS);
    end else if (t_accept) begin
      x_index_d = '0;
    end else if (x_accept) begin
      if (last_x) begin
        // A step is only counted once its final X word lands; x_base advances by a running add.
        t_count_d = t_count_q + COUNT_WIDTH'(1);
        x_index_d = '0;
        x_base_d  = x_base_q + ADDRESS_WIDTH'(num_x);
      end else begin
        x_index_d = x_index_q + COUNT_WIDTH'(1);
      end
    end else begin
      t_count_d = t_count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      t_count_q <= '0;
      x_index_q <= '0;
      x_base_q  <= '0;
    end else begin
      t_count_q <= t_count_d;
      x_index_q <= x_index_d;
      x_base_q  <= x_base_d;
    end
  end

  assign t_count     = t_count_q;
  assign t_count_nxt = t_count_d;
  assign t_addr      = ADDRESS_WIDTH'(STARTING_OF_T_ADDRESS) + ADDRESS_WIDTH'(t_count_q);
  assign x_addr      = x_base_q + ADDRESS_WIDTH'(x_index_q);

endmodule

// File: rtl/results_writer.sv
// Stores the solver's T/X stream into the shared results RAM, then writes the header
// words and raises Done_Writing so the sender may start.
module results_writer
  import results_writer_pkg::*;
#(
  parameter int ADDRESS_WIDTH         = 13,
  parameter int DATA_WIDTH            = 64,
  parameter int COUNT_WIDTH           = 8,
  parameter int NUMBER_OF_T_ADDRESS   = results_writer_pkg::NUMBER_OF_T_ADDRESS,
  parameter int NUMBER_OF_X_ADDRESS   = results_writer_pkg::NUMBER_OF_X_ADDRESS,
  parameter int STARTING_OF_T_ADDRESS = results_writer_pkg::STARTING_OF_T_ADDRESS,
  parameter int STARTING_OF_X_ADDRESS = results_writer_pkg::STARTING_OF_X_ADDRESS,
  parameter int MAX_T                 = results_writer_pkg::MAX_T
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [COUNT_WIDTH-1:0]   Num_X,
  input  logic                     Result_Valid,
  input  logic [DATA_WIDTH-1:0]    Result_Data,
  output logic                     Result_Ready,
  input  logic                     Finish,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic                     RAM_WE,
  output logic [COUNT_WIDTH-1:0]   T_Count,
  output logic                     Done_Writing,
  output logic                     Overflow,
  output logic                     Protocol_Error
);

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     perr_q, perr_d;
  logic [COUNT_WIDTH-1:0]   num_x_q, num_x_d;

  logic                     accept_s, clear_s, t_acc_s, x_acc_s, last_x_s;
  logic [COUNT_WIDTH-1:0]   t_count_s, t_count_nxt_s;
  logic [ADDRESS_WIDTH-1:0] t_addr_s, x_addr_s;

  write_address_gen #(
    .ADDRESS_WIDTH        (ADDRESS_WIDTH),
    .COUNT_WIDTH          (COUNT_WIDTH),
    .STARTING_OF_T_ADDRESS(STARTING_OF_T_ADDRESS),
    .STARTING_OF_X_ADDRESS(STARTING_OF_X_ADDRESS)
  ) u_addr_gen (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (clear_s),
    .t_accept   (t_acc_s),
    .x_accept   (x_acc_s),
    .num_x      (num_x_q),
    .t_count    (t_count_s),
    .t_count_nxt(t_count_nxt_s),
    .last_x     (last_x_s),
    .t_addr     (t_addr_s),
    .x_addr     (x_addr_s)
  );

  assign accept_s = Result_Valid && ready_q;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    num_x_d = num_x_q;
    clear_s = 1'b0;
    t_acc_s = 1'b0;
    x_acc_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          if (Num_X == '0) begin
            perr_d = 1'b1;
          end else begin
            num_x_d = Num_X;
            clear_s = 1'b1;
            done_d  = 1'b0;
            state_d = WAIT_T;
          end
        end else if (state_q == DONE) begin
          // The NX header write is on the bus during the first DONE cycle; flag completion after it.
          done_d = 1'b1;
        end else begin
          done_d = done_q;
        end
      end
      WAIT_T: begin
        if (Start) perr_d = 1'b1;
        if (Result_Valid && (t_count_s >= COUNT_WIDTH'(MAX_T))) ovf_d = 1'b1;
        if (accept_s) begin
          t_acc_s = 1'b1;
          we_d    = 1'b1;
          addr_d  = t_addr_s;
          data_d  = Result_Data;
          // Finish together with a T word leaves a partial step behind.
          if (Finish) begin
            perr_d  = 1'b1;
            state_d = WR_NT;
          end else begin
            state_d = WAIT_X;
          end
        end else if (Finish) begin
          state_d = WR_NT;
        end else begin
          state_d = WAIT_T;
        end
      end
      WAIT_X: begin
        if (Start) perr_d = 1'b1;
        if (accept_s) begin
          x_acc_s = 1'b1;
          we_d    = 1'b1;
          addr_d  = x_addr_s;
          data_d  = Result_Data;
        end
        if (Finish) begin
          perr_d  = 1'b1;
          state_d = WR_NT;
        end else if (accept_s && last_x_s) begin
          state_d = WAIT_T;
        end else begin
          state_d = WAIT_X;
        end
      end
      WR_NT: begin
        if (Start) perr_d = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
        data_d  = DATA_WIDTH'(t_count_s);
        state_d = WR_NX;
      end
      WR_NX: begin
        if (Start) perr_d = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
        data_d  = DATA_WIDTH'(num_x_q);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = ((state_d == WAIT_T) && (t_count_nxt_s < COUNT_WIDTH'(MAX_T))) ||
              (state_d == WAIT_X);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      num_x_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      num_x_q <= num_x_d;
    end
  end

  assign Result_Ready   = ready_q;
  assign RAM_WE         = we_q;
  assign RAM_Address    = addr_q;
  assign RAM_Data       = data_q;
  assign T_Count        = t_count_s;
  assign Done_Writing   = done_q;
  assign Overflow       = ovf_q;
  assign Protocol_Error = perr_q;

endmodule

// File: tb/tb_results_writer.sv
// Directed scoreboard bench for results_writer: expected RAM writes are queued by the
// stimulus and popped by an independent write monitor.
module tb_results_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Num_X = 8'd0;
  logic        Result_Valid = 1'b0;
  logic [63:0] Result_Data = 64'd0;
  logic        Result_Ready;
  logic        Finish = 1'b0;
  logic [12:0] RAM_Address;
  logic [63:0] RAM_Data;
  logic        RAM_WE;
  logic [7:0]  T_Count;
  logic        Done_Writing;
  logic        Overflow;
  logic        Protocol_Error;

  results_writer dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Num_X(Num_X),
    .Result_Valid(Result_Valid), .Result_Data(Result_Data), .Result_Ready(Result_Ready),
    .Finish(Finish), .RAM_Address(RAM_Address), .RAM_Data(RAM_Data), .RAM_WE(RAM_WE),
    .T_Count(T_Count), .Done_Writing(Done_Writing), .Overflow(Overflow),
    .Protocol_Error(Protocol_Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [12:0] a;
    logic [63:0] d;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every RAM write must match the head of the expectation queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (RAM_WE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                   RAM_Address, RAM_Data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(RAM_Address), 64'(e.a));
          chk("wr_data", RAM_Data, e.d);
          if (e.cyc >= 0) chk("wr_latency", 64'(cyc), 64'(e.cyc));
          chk("wr_done_low", 64'(Done_Writing), 64'd0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [12:0] a, input logic [63:0] d, input int c);
    wr_t e;
    e.a = a; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [7:0] n);
    Start = 1'b1; Num_X = n;
    tick(1);
    Start = 1'b0;
  endtask

  // Offer one word and expect it written at address a exactly one cycle after acceptance.
  task automatic send(input logic [63:0] d, input logic [12:0] a);
    int n;
    Result_Valid = 1'b1; Result_Data = d;
    n = 0;
    while (!Result_Ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!Result_Ready) begin
      chk("ready_timeout", 64'(Result_Ready), 64'd1);
    end else begin
      push(a, d, cyc + 1);
    end
    tick(1);
    Result_Valid = 1'b0;
  endtask

  task automatic finish(input logic [7:0] nt, input logic [7:0] nx);
    push(13'd1, 64'(nt), -1);
    push(13'd2, 64'(nx), -1);
    Finish = 1'b1;
    tick(1);
    Finish = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!Done_Writing && n < 20) begin
      tick(1);
      n++;
    end
    chk("done_writing", 64'(Done_Writing), 64'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 64'(Result_Ready), 64'd0);
    chk("rst_we", 64'(RAM_WE), 64'd0);
    chk("rst_addr", 64'(RAM_Address), 64'd0);
    chk("rst_data", RAM_Data, 64'd0);
    chk("rst_tcount", 64'(T_Count), 64'd0);
    chk("rst_done", 64'(Done_Writing), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    chk("rst_perr", 64'(Protocol_Error), 64'd0);
  endtask

  initial begin
    tick(3);
    chk_reset_outputs();
    RST = 1'b0;
    tick(1);

    // Basic set with Num_X = 2
    start(8'd2);
    send(64'd5, 13'd3);  send(64'd11, 13'd10); send(64'd12, 13'd11);
    send(64'd6, 13'd4);  send(64'd13, 13'd12); send(64'd14, 13'd13);
    finish(8'd2, 8'd2);
    wait_done();
    chk("basic_tcount", 64'(T_Count), 64'd2);
    chk("basic_perr", 64'(Protocol_Error), 64'd0);
    chk("basic_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: valid toggles every other cycle, restart from DONE with Num_X = 3
    start(8'd3);
    chk("restart_done_clr", 64'(Done_Writing), 64'd0);
    chk("restart_tcount", 64'(T_Count), 64'd0);
    send(64'd7, 13'd3);  tick(1);
    send(64'd21, 13'd10); tick(1);
    send(64'd22, 13'd11); tick(1);
    send(64'd23, 13'd12); tick(1);
    finish(8'd1, 8'd3);
    wait_done();
    chk("bp_tcount", 64'(T_Count), 64'd1);

    // Full: Num_X = 1, seven complete steps, eighth T refused
    start(8'd1);
    for (int i = 0; i < 7; i++) begin
      send(64'(100 + i), 13'(3 + i));
      send(64'(200 + i), 13'(10 + i));
    end
    Result_Valid = 1'b1; Result_Data = 64'd999;
    tick(3);
    chk("full_ready", 64'(Result_Ready), 64'd0);
    chk("full_ovf", 64'(Overflow), 64'd1);
    Result_Valid = 1'b0;
    finish(8'd7, 8'd1);
    wait_done();
    chk("full_tcount", 64'(T_Count), 64'd7);
    chk("full_perr", 64'(Protocol_Error), 64'd0);

    // Partial step: Num_X = 3, T and one X, then Finish
    do_reset();
    start(8'd3);
    send(64'd9, 13'd3);
    send(64'd31, 13'd10);
    finish(8'd0, 8'd3);
    wait_done();
    chk("partial_perr", 64'(Protocol_Error), 64'd1);
    chk("partial_tcount", 64'(T_Count), 64'd0);
    chk("partial_ovf", 64'(Overflow), 64'd0);

    // Illegal Start: Num_X = 0 in IDLE, then Start during WAIT_X
    do_reset();
    start(8'd0);
    tick(1);
    chk("illegal_idle_ready", 64'(Result_Ready), 64'd0);
    chk("illegal_idle_perr", 64'(Protocol_Error), 64'd1);
    start(8'd2);
    send(64'd70, 13'd3);
    send(64'd71, 13'd10);
    start(8'd5);
    chk("illegal_wx_tcount", 64'(T_Count), 64'd0);
    send(64'd72, 13'd11);
    chk("illegal_wx_step", 64'(T_Count), 64'd1);
    send(64'd73, 13'd4);
    finish(8'd1, 8'd2);
    wait_done();

    // Reset mid-stream, one cycle after an X word is accepted
    do_reset();
    start(8'd2);
    send(64'd1, 13'd3);
    send(64'd2, 13'd10);
    RST = 1'b1;
    tick(1);
    chk_reset_outputs();
    RST = 1'b0;
    tick(1);
    start(8'd4);
    send(64'd50, 13'd3);
    send(64'd51, 13'd10);
    chk("midrst_tcount", 64'(T_Count), 64'd0);
    do_reset();
    tick(3);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
